// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C init sequencer: command opcodes, FSM states and the ROM entry layout.
package i2c_seq_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned CMD_WIDTH  = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_DELAY = 2'b01,
    OP_END   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StSend,
    StWait,
    StDone
  } seq_state_e;

  typedef struct packed {
    op_e                   op;
    logic [DATA_WIDTH-1:0] payload;
  } cmd_t;

endpackage

// File: rtl/axis_i2c_init_seq_if.sv
// AXI-Stream link from the init sequencer to the I2C master's command FIFO.
interface axis_i2c_init_seq_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/i2c_init_rom.sv
// Synchronous command ROM; contents come from the INIT parameter, data valid one cycle after addr.
module i2c_init_rom
  import i2c_seq_pkg::*;
#(
  parameter int unsigned NUM_CMDS = 16,
  parameter int unsigned ADDR_W   = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1,
  parameter logic [CMD_WIDTH-1:0] INIT [NUM_CMDS] = '{default: {OP_END, {DATA_WIDTH{1'b0}}}}
) (
  input  logic                 clk_i,
  input  logic [ADDR_W-1:0]    addr_i,
  output logic [CMD_WIDTH-1:0] data_o
);

  logic [CMD_WIDTH-1:0] data_q;

  // Addresses past the table read back as END so a stray fetch terminates cleanly.
  always_ff @(posedge clk_i) begin
    if (32'(addr_i) < NUM_CMDS) begin
      data_q <= INIT[addr_i];
    end else begin
      data_q <= {OP_END, {DATA_WIDTH{1'b0}}};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/axis_i2c_init_seq.sv
// Table-driven I2C init sequencer: walks a command ROM and streams write words to the I2C FIFO.
module axis_i2c_init_seq
  import i2c_seq_pkg::*;
#(
  parameter int unsigned NUM_CMDS = 16,
  localparam int unsigned ADDR_W  = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [ADDR_W-1:0]    rom_addr_o,
  input  logic [CMD_WIDTH-1:0] rom_data_i,
  axis_i2c_init_seq_if.master  m_axis
);

  seq_state_e state_q, state_d;

  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  err_q, err_d;
  logic                  advance;
  logic                  last_entry;
  cmd_t                  cmd;

  assign cmd        = cmd_t'(rom_data_i);
  // Compare before incrementing so a non-power-of-two table never overflows the address.
  assign last_entry = (addr_q == ADDR_W'(NUM_CMDS - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (cmd.op)
          OP_WRITE: state_d = StSend;
          OP_DELAY: begin
            if (cmd.payload != '0) begin
              state_d = StWait;
            end else begin
              advance = 1'b1;
            end
          end
          OP_END:   state_d = StDone;
          OP_RSVD:  state_d = StDone;
          default:  state_d = StDone;
        endcase
      end
      StSend:   if (m_axis.tready) advance = 1'b1;
      StWait:   if (cnt_q == DATA_WIDTH'(1)) advance = 1'b1;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (advance) begin
      state_d = last_entry ? StDone : StFetch;
    end
  end

  // Datapath next-state
  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    tdata_d = tdata_q;
    err_d   = err_q;
    if (state_q == StIdle && start_i) begin
      addr_d = '0;
      err_d  = 1'b0;
    end
    if (state_q == StDecode) begin
      unique case (cmd.op)
        OP_WRITE: tdata_d = cmd.payload;
        OP_DELAY: cnt_d   = cmd.payload;
        OP_RSVD:  err_d   = 1'b1;
        default:  ;
      endcase
    end
    if (state_q == StWait) begin
      cnt_d = cnt_q - DATA_WIDTH'(1);
    end
    if (advance && !last_entry) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      tdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      tdata_q <= tdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs: tvalid is purely a state decode, so there is no path from tready.
  always_comb begin
    busy_o        = (state_q != StIdle);
    done_o        = (state_q == StDone);
    err_o         = err_q;
    rom_addr_o    = addr_q;
    m_axis.tvalid = (state_q == StSend);
    m_axis.tdata  = tdata_q;
  end

endmodule
